// File: rtl/sqrt_pkg.sv
// Shared definitions for the square-root engine:
// state encoding and data-memory addresses.
package sqrt_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_RD_HI = 3'd1;
    localparam state_t S_RD_LO = 3'd2;
    localparam state_t S_CALC  = 3'd3;
    localparam state_t S_WR    = 3'd4;
    localparam state_t S_DONE  = 3'd5;

    localparam logic [7:0] OPND_HI_ADDR = 8'd16;
    localparam logic [7:0] OPND_LO_ADDR = 8'd17;
    localparam logic [7:0] RESULT_ADDR  = 8'd18;

endpackage

// File: rtl/sqrt_step.sv
// One restoring digit-by-digit square-root iteration,
// purely combinational.
module sqrt_step (
    input  logic [10:0] rem,
    input  logic [7:0]  root,
    input  logic [1:0]  bits,
    output logic [10:0] rem_next,
    output logic [7:0]  root_next
);

    logic [10:0] rem_sh;
    logic [10:0] trial;

    assign rem_sh = (rem << 2) | {9'd0, bits};
    assign trial  = {1'b0, root, 2'b01};

    always_comb begin
        rem_next  = rem_sh;
        root_next = root << 1;
        if (rem_sh >= trial) begin
            rem_next  = rem_sh - trial;
            root_next = (root << 1) | 8'd1;
        end
    end

endmodule

// File: rtl/sqrt_engine.sv
// Start/ack square-root responder: reads a 16-bit operand
// from data memory, writes floor(sqrt) back, raises Ack.
module sqrt_engine
    import sqrt_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    output logic       Ack,
    output logic       Busy,
    output logic [7:0] MemAddr,
    input  logic [7:0] MemRdData,
    output logic       MemWrEn,
    output logic [7:0] MemWrData
);

    state_t      state;
    state_t      next_state;
    logic        start_q;
    logic [15:0] opnd;
    logic [7:0]  root;
    logic [10:0] rem;
    logic [2:0]  iter;
    logic [3:0]  msb;
    logic [1:0]  pair;
    logic [10:0] rem_next;
    logic [7:0]  root_next;

    // Operand pair for this iteration, most significant first.
    assign msb  = 4'd15 - {iter, 1'b0};
    assign pair = opnd[msb -: 2];

    sqrt_step u_step (
        .rem       (rem),
        .root      (root),
        .bits      (pair),
        .rem_next  (rem_next),
        .root_next (root_next)
    );

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (!Start && start_q) next_state = S_RD_HI;
            S_RD_HI: next_state = S_RD_LO;
            S_RD_LO: next_state = S_CALC;
            S_CALC:  if (iter == 3'd7) next_state = S_WR;
            S_WR:    next_state = S_DONE;
            S_DONE:  if (Start) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= S_IDLE;
            start_q <= 1'b0;
            Ack     <= 1'b0;
            Busy    <= 1'b0;
            opnd    <= '0;
            root    <= '0;
            rem     <= '0;
            iter    <= '0;
        end else begin
            state   <= next_state;
            start_q <= Start;
            Ack     <= (next_state == S_DONE);
            Busy    <= (next_state != S_IDLE) && (next_state != S_DONE);
            case (state)
                S_RD_HI: opnd[15:8] <= MemRdData;
                S_RD_LO: begin
                    opnd[7:0] <= MemRdData;
                    root      <= '0;
                    rem       <= '0;
                    iter      <= '0;
                end
                S_CALC: begin
                    rem  <= rem_next;
                    root <= root_next;
                    iter <= iter + 3'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        MemAddr   = 8'd0;
        MemWrEn   = 1'b0;
        MemWrData = 8'd0;
        case (state)
            S_RD_HI: MemAddr = OPND_HI_ADDR;
            S_RD_LO: MemAddr = OPND_LO_ADDR;
            S_WR: begin
                MemAddr   = RESULT_ADDR;
                MemWrEn   = 1'b1;
                MemWrData = root;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sqrt_engine.sv
// Bench for sqrt_engine: directed launch scenarios plus random
// operands against an arithmetic floor-sqrt model.
module tb_sqrt_engine;
    import sqrt_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Start = 1'b0;
    logic       Ack;
    logic       Busy;
    logic [7:0] MemAddr;
    logic [7:0] MemRdData;
    logic       MemWrEn;
    logic [7:0] MemWrData;

    logic [7:0] opnd_hi = 8'd0;
    logic [7:0] opnd_lo = 8'd0;
    logic [7:0] res_mem = 8'd0;
    logic [7:0] last_wr_addr = 8'd0;
    int         writes = 0;

    int vectors = 0;
    int miscompares = 0;

    sqrt_engine dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Ack       (Ack),
        .Busy      (Busy),
        .MemAddr   (MemAddr),
        .MemRdData (MemRdData),
        .MemWrEn   (MemWrEn),
        .MemWrData (MemWrData)
    );

    always #5 Clk = ~Clk;

    assign MemRdData = (MemAddr == OPND_HI_ADDR) ? opnd_hi :
                       (MemAddr == OPND_LO_ADDR) ? opnd_lo : 8'h00;

    always @(posedge Clk) begin
        if (MemWrEn) begin
            if (MemAddr == RESULT_ADDR) res_mem <= MemWrData;
            last_wr_addr <= MemAddr;
            writes <= writes + 1;
        end
    end

    function automatic int ref_sqrt(input int n);
        int r = 0;
        while ((r + 1) * (r + 1) <= n) r++;
        return r;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        #2;
        Reset = 1'b1;
    endtask

    // Leaves the bench just after E0.
    task automatic launch_e0(input logic [15:0] n);
        opnd_hi = n[15:8];
        opnd_lo = n[7:0];
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        while (Ack !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic run(input string tag, input logic [15:0] n);
        int lat;
        int w0;
        w0 = writes;
        launch_e0(n);
        chk({tag, "_busy_e0"}, int'(Busy), 1);
        wait_ack(lat);
        chk({tag, "_ack_lat"}, lat, 11);
        chk({tag, "_root"}, int'(res_mem), ref_sqrt(int'(n)));
        chk({tag, "_writes"}, writes - w0, 1);
    endtask

    initial begin
        int lat;
        int w0;
        logic [7:0] prev;
        logic [15:0] dir [9] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4,
                                 16'd15, 16'd16, 16'd255, 16'd256};

        tick();
        tick();
        chk("rst_ack", int'(Ack), 0);
        chk("rst_busy", int'(Busy), 0);
        chk("rst_wren", int'(MemWrEn), 0);
        chk("rst_addr", int'(MemAddr), 0);
        chk("rst_wrdata", int'(MemWrData), 0);
        Reset = 1'b1;
        tick();

        run("ffff", 16'hFFFF);
        chk("ffff_addr", int'(last_wr_addr), int'(RESULT_ADDR));
        chk("ffff_val", int'(res_mem), 255);
        chk("done_addr", int'(MemAddr), 0);
        chk("done_busy", int'(Busy), 0);

        foreach (dir[i]) begin
            do_reset();
            run($sformatf("dir%0d", dir[i]), dir[i]);
        end

        // Abort mid-calculation: result cell must keep the old root.
        do_reset();
        run("pre_abort", 16'd100);
        prev = res_mem;
        w0 = writes;
        launch_e0(16'hFFFF);
        repeat (6) tick();
        Reset = 1'b0;
        #1;
        chk("abort_ack", int'(Ack), 0);
        chk("abort_busy", int'(Busy), 0);
        chk("abort_addr", int'(MemAddr), 0);
        chk("abort_wren", int'(MemWrEn), 0);
        repeat (15) tick();
        chk("abort_writes", writes - w0, 0);
        chk("abort_mem", int'(res_mem), int'(prev));
        Reset = 1'b1;
        tick();
        run("post_abort", 16'd50000);

        // Start edges while busy are ignored.
        do_reset();
        w0 = writes;
        launch_e0(16'd1000);
        repeat (2) tick();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        wait_ack(lat);
        chk("tog_lat", lat + 4, 11);
        chk("tog_writes", writes - w0, 1);
        chk("tog_root", int'(res_mem), 31);
        repeat (3) tick();
        chk("done_hold_ack", int'(Ack), 1);
        Start = 1'b1;
        tick();
        chk("done_exit_ack", int'(Ack), 0);
        opnd_hi = 8'h12;
        opnd_lo = 8'h34;
        Start = 1'b0;
        tick();
        wait_ack(lat);
        chk("relaunch_lat", lat, 11);
        chk("relaunch_root", int'(res_mem), ref_sqrt(16'h1234));

        // Start held high in IDLE never launches.
        do_reset();
        w0 = writes;
        Start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("hold_busy", int'(Busy), 0);
            chk("hold_addr", int'(MemAddr), 0);
        end
        chk("hold_writes", writes - w0, 0);
        Start = 1'b0;
        tick();
        chk("hold_fall_busy", int'(Busy), 1);
        wait_ack(lat);
        chk("hold_fall_lat", lat, 11);

        for (int k = 0; k < 1500; k++) begin
            logic [15:0] n;
            n = 16'($urandom);
            do_reset();
            run("rand", n);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
